// File: rtl/and3_sweep_pkg.sv
// Shared types and sizing for the 3-input AND gate sweep controller.
package and3_sweep_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  localparam int unsigned NUM_VECTORS = 8;
  localparam int unsigned VEC_W       = 3;
  localparam int unsigned ERR_W       = 4;
  localparam int unsigned CNT_W       = 4;

  localparam logic [VEC_W-1:0] VEC_LAST = VEC_W'(NUM_VECTORS - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = ERR_W'(NUM_VECTORS);

endpackage

// File: rtl/and3_sweep_ctrl.sv
// Walks {x,y,w} through 000..111, samples z after a settle window and
// accumulates mismatch statistics against the ideal AND of the vector.
module and3_sweep_ctrl
  import and3_sweep_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             z,
  output logic             x,
  output logic             y,
  output logic             w,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [ERR_W-1:0] err_count,
  output logic [VEC_W-1:0] first_fail_vec,
  output state_t           state_dbg
);

  // Handshake: start is a level sampled on a rising edge; it is accepted only
  // when the FSM is in IDLE, otherwise dropped. busy rises on the accepting
  // edge and falls on the same edge that raises the one-cycle done pulse.

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state, state_next;
  logic [VEC_W-1:0] vec, vec_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             mismatch;
  logic             drive_vec;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    vec_next   = vec;
    cnt_next   = cnt;
    case (state)
      ST_IDLE: begin
        if (start) begin
          state_next = ST_SETTLE;
          vec_next   = '0;
          cnt_next   = '0;
        end
      end
      ST_SETTLE: begin
        if (cnt == CNT_LAST) begin
          state_next = ST_CHECK;
          cnt_next   = '0;
        end else begin
          cnt_next = cnt + 1'b1;
        end
      end
      ST_CHECK: begin
        if (vec == VEC_LAST) begin
          state_next = ST_DONE;
        end else begin
          state_next = ST_SETTLE;
          vec_next   = vec + 1'b1;
          cnt_next   = '0;
        end
      end
      ST_DONE: state_next = ST_IDLE;
      default: state_next = ST_IDLE;
    endcase
  end

  // z only matters on the edge that closes a CHECK cycle.
  assign mismatch  = (state == ST_CHECK) && (z != (&vec));
  assign drive_vec = (state_next == ST_SETTLE) || (state_next == ST_CHECK);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vec            <= '0;
      cnt            <= '0;
      x              <= 1'b0;
      y              <= 1'b0;
      w              <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
      pass           <= 1'b0;
      err_count      <= '0;
      first_fail_vec <= '0;
    end else begin
      vec       <= vec_next;
      cnt       <= cnt_next;
      done      <= 1'b0;
      {x, y, w} <= drive_vec ? vec_next : '0;
      if (state == ST_IDLE && start) begin
        busy           <= 1'b1;
        pass           <= 1'b0;
        err_count      <= '0;
        first_fail_vec <= '0;
      end
      if (mismatch) begin
        if (err_count != ERR_MAX) err_count <= err_count + 1'b1;
        if (err_count == '0)      first_fail_vec <= vec;
      end
      // The DONE cycle publishes its results on the edge that leaves it.
      if (state == ST_DONE) begin
        done <= 1'b1;
        busy <= 1'b0;
        pass <= (err_count == '0);
      end
    end
  end

  assign state_dbg = state;

endmodule

// File: tb/tb_and3_sweep_ctrl.sv
// Directed bench for and3_sweep_ctrl with a behavioural gate model that can
// be switched between good, stuck-at-0, stuck-at-1 and inverted outputs.
module tb_and3_sweep_ctrl;
  import and3_sweep_pkg::*;

  localparam logic [1:0] G_GOOD = 2'd0, G_ST0 = 2'd1, G_ST1 = 2'd2, G_INV = 2'd3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic start2 = 1'b0, start1 = 1'b0;
  logic [1:0] mode2 = G_GOOD, mode1 = G_GOOD;
  logic z2, x2, y2, w2, busy2, done2, pass2;
  logic z1, x1, y1, w1, busy1, done1, pass1;
  logic [ERR_W-1:0] err2, err1;
  logic [VEC_W-1:0] ff2, ff1;
  state_t st2, st1;

  int n_assert = 0;
  int n_fail   = 0;
  int done2_cnt = 0;
  int done1_cnt = 0;
  int lat;
  int seen;

  always #5 clk = ~clk;

  function automatic logic gate(input logic [1:0] m, input logic a, input logic b, input logic c);
    case (m)
      G_ST0:   return 1'b0;
      G_ST1:   return 1'b1;
      G_INV:   return ~(a & b & c);
      default: return a & b & c;
    endcase
  endfunction

  assign z2 = gate(mode2, x2, y2, w2);
  assign z1 = gate(mode1, x1, y1, w1);

  and3_sweep_ctrl #(.SETTLE_CYCLES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .start(start2), .z(z2),
    .x(x2), .y(y2), .w(w2), .busy(busy2), .done(done2), .pass(pass2),
    .err_count(err2), .first_fail_vec(ff2), .state_dbg(st2)
  );

  and3_sweep_ctrl #(.SETTLE_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .z(z1),
    .x(x1), .y(y1), .w(w1), .busy(busy1), .done(done1), .pass(pass1),
    .err_count(err1), .first_fail_vec(ff1), .state_dbg(st1)
  );

  always @(negedge clk) begin
    if (done2) done2_cnt++;
    if (done1) done1_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Returns at the negedge just after the edge that samples start.
  task automatic start_sweep2();
    @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
  endtask

  // lat counts edges after the start-sampling edge until done is seen.
  task automatic wait_done2(input bit chk_order);
    lat = 0;
    while (!done2 && lat < 200) begin
      @(negedge clk);
      lat++;
      if (chk_order && lat < 24 && (lat % 3) == 1)
        chk("vec_order", {29'd0, x2, y2, w2}, lat / 3);
    end
  endtask

  task automatic check_results2(input string tag, input int e_err, input int e_ff, input bit e_pass);
    chk({tag, "_latency"}, lat, 25);
    chk({tag, "_done"}, done2, 1'b1);
    chk({tag, "_busy_at_done"}, busy2, 1'b0);
    chk({tag, "_err"}, err2, e_err);
    chk({tag, "_ffv"}, ff2, e_ff);
    chk({tag, "_pass"}, pass2, e_pass);
    @(negedge clk);
    chk({tag, "_done_one_cycle"}, done2, 1'b0);
  endtask

  initial begin
    // Reset state
    #1;
    chk("rst_xyw", {x2, y2, w2}, 0);
    chk("rst_busy_done_pass", {busy2, done2, pass2}, 0);
    chk("rst_err_ffv", {err2, ff2}, 0);
    chk("rst_state", st2, ST_IDLE);
    chk("rst_dut1_all", {x1, y1, w1, busy1, done1, pass1, err1, ff1}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Good gate, full sweep with vector order
    mode2 = G_GOOD;
    start_sweep2();
    chk("good_busy_after_start", busy2, 1'b1);
    chk("good_first_vec", {x2, y2, w2}, 0);
    wait_done2(1'b1);
    check_results2("good", 0, 0, 1'b1);

    // Stuck-at-0: only vector 111 mismatches
    mode2 = G_ST0;
    start_sweep2();
    wait_done2(1'b0);
    check_results2("st0", 1, 7, 1'b0);
    repeat (3) @(negedge clk);
    chk("st0_hold_idle", {pass2, err2, ff2}, {1'b0, 4'd1, 3'd7});
    chk("st0_idle_xyw", {x2, y2, w2}, 0);

    // Back-to-back good sweep clears stale results
    mode2 = G_GOOD;
    start_sweep2();
    chk("b2b_err_cleared", {err2, ff2}, 0);
    wait_done2(1'b0);
    check_results2("b2b_good", 0, 0, 1'b1);

    // Stuck-at-1: vectors 000..110 mismatch
    mode2 = G_ST1;
    start_sweep2();
    chk("st1_pass_cleared", pass2, 1'b0);
    wait_done2(1'b0);
    check_results2("st1", 7, 0, 1'b0);

    // Inverted gate: every vector mismatches, err_count reaches 8
    mode2 = G_INV;
    start_sweep2();
    wait_done2(1'b0);
    check_results2("inv", 8, 0, 1'b0);

    // SETTLE_CYCLES=1 with an extra start while busy
    mode1 = G_GOOD;
    done1_cnt = 0;
    @(negedge clk);
    start1 = 1'b1;
    @(negedge clk);
    start1 = 1'b0;
    lat = 0;
    while (!done1 && lat < 200) begin
      @(negedge clk);
      lat++;
      start1 = (lat == 4);
    end
    start1 = 1'b0;
    chk("s1_latency", lat, 17);
    chk("s1_results", {pass1, err1, ff1}, {1'b1, 4'd0, 3'd0});
    repeat (40) @(negedge clk);
    chk("s1_single_done", done1_cnt, 1);
    chk("s1_idle", st1, ST_IDLE);

    // Reset while vector 100 is applied
    mode2 = G_ST1;
    start_sweep2();
    seen = 0;
    while ({x2, y2, w2} != 3'b100 && seen < 100) begin
      @(negedge clk);
      seen++;
    end
    chk("mid_reached_vec4", {x2, y2, w2}, 3'b100);
    chk("mid_err_before_reset", err2, 4);
    done2_cnt = 0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_async_clear", {x2, y2, w2, busy2, done2, pass2, err2, ff2}, 0);
    chk("mid_state_idle", st2, ST_IDLE);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    chk("mid_no_done", done2_cnt, 0);
    mode2 = G_GOOD;
    start_sweep2();
    chk("post_rst_first_vec", {x2, y2, w2}, 0);
    wait_done2(1'b1);
    check_results2("post_rst", 0, 0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
